// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 core: opcodes, sequencer states,
// instruction field positions and a small immediate helper.
package tiny16_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_LDI = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_JMP = 4'hA,
    OP_JZ  = 4'hB,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_FETCH_REQ = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_MEM       = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Instruction layout: [15:12] opcode, [11:9] dst, [8:6] src, [5:0] imm6
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 9;
  localparam int SRC_MSB = 8;
  localparam int SRC_LSB = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  function automatic logic [15:0] sext_imm6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational ALU for the data ops: result = a op b, plus a zero flag.
// a is the destination operand, b the source operand.
module alu16
  import tiny16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  op,
  output logic [15:0] result,
  output logic        zero
);

  // Select the operation; non-ALU opcodes produce zero and are never used.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
    zero = (result == 16'h0000);
  end

endmodule

// File: rtl/control_unit.sv
// tiny16 multi-cycle sequencer: FETCH -> FETCH_REQ -> DECODE -> EXEC [-> MEM].
// The PC lives in the register file as R0 (reset value 16'h0000 is held
// there, not here). Register reads are registered in the file, so a select
// driven in one cycle is visible on reg_src/reg_dst in the next.
//
// Memory handshake: mem_req qualifies mem_we/mem_addr/mem_wdata, which hold
// steady until the cycle mem_ack=1 closes the transfer; mem_req drops the
// following cycle, and mem_ack is ignored whenever mem_req is low.
module control_unit
  import tiny16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_src,
  input  logic [15:0] reg_dst,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic        in_en,
  output logic        out_en,
  output logic        pc_inc,
  output logic [15:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        halted,
  output logic [2:0]  fsm_state
);

  state_e      state, state_nx;
  logic [15:0] ir;
  logic        zf;
  logic        ir_load;
  logic        z_load;
  logic [15:0] alu_result;
  logic        alu_zero;

  opcode_e     opcode;
  logic [2:0]  ir_dst;
  logic [2:0]  ir_src;
  logic [5:0]  ir_imm;

  assign opcode = opcode_e'(ir[OPC_MSB:OPC_LSB]);
  assign ir_dst = ir[DST_MSB:DST_LSB];
  assign ir_src = ir[SRC_MSB:SRC_LSB];
  assign ir_imm = ir[IMM_MSB:IMM_LSB];

  alu16 u_alu (
    .a      (reg_dst),
    .b      (reg_src),
    .op     (ir[OPC_MSB:OPC_LSB]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // State register, instruction register and zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
      zf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load) ir <= mem_rdata;
      if (z_load)  zf <= alu_zero;
    end
  end

  // Next state and all control outputs; everything is forced low during reset
  // so an interrupted transfer is dropped immediately.
  always_comb begin
    state_nx  = state;
    src_sel   = '0;
    dst_sel   = '0;
    in_en     = 1'b0;
    out_en    = 1'b0;
    pc_inc    = 1'b0;
    wb_data   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    ir_load   = 1'b0;
    z_load    = 1'b0;
    fsm_state = '0;
    if (!rst) begin
      fsm_state = state;
      case (state)
        ST_FETCH: begin
          src_sel  = 3'd0;
          state_nx = ST_FETCH_REQ;
        end
        ST_FETCH_REQ: begin
          // src_sel stays at R0 so reg_src (the PC) is stable while waiting.
          mem_req  = 1'b1;
          mem_addr = reg_src;
          if (mem_ack) begin
            ir_load  = 1'b1;
            pc_inc   = 1'b1;
            state_nx = ST_DECODE;
          end
        end
        ST_DECODE: begin
          src_sel  = ir_src;
          dst_sel  = ir_dst;
          state_nx = ST_EXEC;
        end
        ST_EXEC: begin
          src_sel  = ir_src;
          dst_sel  = ir_dst;
          state_nx = ST_FETCH;
          case (opcode)
            OP_MOV: begin
              in_en   = 1'b1;
              wb_data = reg_src;
            end
            OP_LDI: begin
              in_en   = 1'b1;
              wb_data = sext_imm6(ir_imm);
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              in_en   = 1'b1;
              wb_data = alu_result;
              z_load  = 1'b1;
            end
            OP_JMP: begin
              dst_sel = 3'd0;
              in_en   = 1'b1;
              wb_data = reg_src;
            end
            OP_JZ: begin
              if (zf) begin
                dst_sel = 3'd0;
                in_en   = 1'b1;
                wb_data = reg_src;
              end
            end
            OP_LD, OP_ST: state_nx = ST_MEM;
            OP_HLT:       state_nx = ST_HALT;
            default:      state_nx = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          src_sel = ir_src;
          dst_sel = ir_dst;
          mem_req = 1'b1;
          if (opcode == OP_ST) begin
            mem_we    = 1'b1;
            mem_addr  = reg_dst;
            mem_wdata = reg_src;
            out_en    = 1'b1;
            if (mem_ack) state_nx = ST_FETCH;
          end else begin
            mem_addr = reg_src;
            if (mem_ack) begin
              in_en    = 1'b1;
              wb_data  = mem_rdata;
              state_nx = ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          halted   = 1'b1;
          state_nx = ST_HALT;
        end
        default: state_nx = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: register file and memory models around the DUT,
// expected events queued per program, a negedge monitor pops and compares.
module tb_control_unit;

  localparam int EW = 37;
  localparam logic [1:0] K_RD = 2'd0;  // memory read ack  (sel[0] = pc_inc)
  localparam logic [1:0] K_WT = 2'd1;  // memory write ack (sel[0] = out_en)
  localparam logic [1:0] K_WR = 2'd2;  // register write   (sel = dst_sel)

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] reg_src, reg_dst;
  logic [2:0]  src_sel, dst_sel;
  logic        in_en, out_en, pc_inc;
  logic [15:0] wb_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        halted;
  logic [2:0]  fsm_state;

  logic [15:0] gpr [8];
  logic [15:0] mem_arr [65536];
  logic [EW-1:0] exp_q [$];
  bit          hold_ld;
  int          n_cmp;
  int          n_fail;

  control_unit dut (
    .clk(clk), .rst(rst), .reg_src(reg_src), .reg_dst(reg_dst),
    .src_sel(src_sel), .dst_sel(dst_sel), .in_en(in_en), .out_en(out_en),
    .pc_inc(pc_inc), .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .halted(halted), .fsm_state(fsm_state)
  );

  // clock / safety limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [EW-1:0] ev(logic [1:0] k, logic [2:0] s, logic [15:0] a, logic [15:0] d);
    return {k, s, a, d};
  endfunction

  function automatic int ack_delay(logic [15:0] a, logic we);
    return (a == 16'h0100 && !we) ? 3 : 0;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(string name, logic [EW-1:0] got);
    logic [EW-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event %h (queue empty)", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, got, e);
      end
    end
  endtask

  task automatic push_fetch(logic [15:0] a);
    exp_q.push_back(ev(K_RD, 3'b001, a, 16'h0));
  endtask

  task automatic push_rd(logic [15:0] a);
    exp_q.push_back(ev(K_RD, 3'b000, a, 16'h0));
  endtask

  task automatic push_wt(logic [15:0] a, logic [15:0] d);
    exp_q.push_back(ev(K_WT, 3'b001, a, d));
  endtask

  task automatic push_wr(logic [2:0] s, logic [15:0] d);
    exp_q.push_back(ev(K_WR, s, 16'h0, d));
  endtask

  task automatic set_rst(logic v);
    @(negedge clk);
    #1 rst = v;
  endtask

  task automatic wait_halted(int max, string name);
    for (int i = 0; i < max && !halted; i++) @(negedge clk);
    check(name, halted, 1'b1);
  endtask

  task automatic wait_drain(int max, string name);
    for (int i = 0; i < max && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  // register file model: registered reads of pre-edge contents
  initial begin
    logic [2:0]  s, d;
    logic        ie, pi, r;
    logic [15:0] wd;
    reg_src = '0;
    reg_dst = '0;
    forever begin
      @(posedge clk);
      s = src_sel; d = dst_sel; ie = in_en; pi = pc_inc; wd = wb_data; r = rst;
      #1;
      reg_src = gpr[s];
      reg_dst = gpr[d];
      if (r) gpr[0] = 16'h0000;
      else begin
        if (ie) gpr[d] = wd;
        if (pi) gpr[0] = gpr[0] + 16'h0001;
      end
    end
  end

  // memory model: acks after ack_delay wait cycles
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (!rst && mem_req && mem_ack && mem_we) mem_arr[mem_addr] = mem_wdata;
      #2;
      if (rst || !mem_req) begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        cnt = 0;
      end else begin
        if (!(hold_ld && !mem_we && mem_addr == 16'h00FF) && cnt >= ack_delay(mem_addr, mem_we)) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 16'h0000 : mem_arr[mem_addr];
        end else begin
          mem_ack = 1'b0;
        end
        cnt++;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    int          req_len;
    logic [15:0] h_addr, h_wdata;
    logic        h_we, stable;
    req_len = 0; stable = 1'b1; h_addr = '0; h_wdata = '0; h_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs",
              {src_sel, dst_sel, in_en, out_en, pc_inc, mem_req, mem_we,
               mem_addr, mem_wdata, wb_data, halted}, 64'h0);
        req_len = 0;
      end else begin
        if (mem_req) begin
          if (req_len == 0) begin
            h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata; stable = 1'b1;
          end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
            stable = 1'b0;
          end
          req_len++;
          if (mem_ack) begin
            if (mem_we) sb_pop("mem_write", ev(K_WT, {2'b00, out_en}, mem_addr, mem_wdata));
            else        sb_pop("mem_read", ev(K_RD, {2'b00, pc_inc}, mem_addr, 16'h0));
            check("req_len", req_len, ack_delay(mem_addr, mem_we) + 1);
            check("req_stable", stable, 1'b1);
            req_len = 0;
          end
        end else begin
          req_len = 0;
        end
        if (in_en) sb_pop("reg_write", ev(K_WR, dst_sel, 16'h0, wb_data));
        if (pc_inc) check("pc_inc_only_on_fetch_ack", {in_en, mem_req & mem_ack & ~mem_we}, 2'b01);
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    hold_ld = 1'b0;
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    for (int i = 0; i < 8; i++) gpr[i] = 16'h0000;
    gpr[1] = 16'h00FF; gpr[4] = 16'h0040; gpr[5] = 16'h0001; gpr[6] = 16'h0200;

    // phase 1 program
    mem_arr[16'h0000] = 16'h243F;  // LDI R2,#-1
    mem_arr[16'h0001] = 16'hB040;  // JZ R1 (Z=0, not taken)
    mem_arr[16'h0002] = 16'h4480;  // SUB R2,R2 -> 0, Z=1
    mem_arr[16'h0003] = 16'hB040;  // JZ R1 (taken to 0x00FF)
    mem_arr[16'h0040] = 16'h1234;
    mem_arr[16'h00FF] = 16'h8500;  // LD R2,[R4]
    mem_arr[16'h0100] = 16'h9280;  // ST [R1],R2 (fetched with 3 wait cycles)
    mem_arr[16'h0101] = 16'h3A40;  // ADD R5,R1 -> 0x0100
    mem_arr[16'h0102] = 16'h5A80;  // AND R5,R2 -> 0x0000
    mem_arr[16'h0103] = 16'h6A80;  // OR  R5,R2 -> 0x1234
    mem_arr[16'h0104] = 16'h1E40;  // MOV R7,R1 -> 0x00FF
    mem_arr[16'h0105] = 16'h7A80;  // XOR R5,R2 -> 0x0000
    mem_arr[16'h0106] = 16'hA180;  // JMP R6 -> 0x0200
    mem_arr[16'h0200] = 16'h8640;  // LD R3,[R1] -> stored 0x1234
    mem_arr[16'h0201] = 16'hF000;  // HLT

    push_fetch(16'h0000); push_wr(3'd2, 16'hFFFF);
    push_fetch(16'h0001);
    push_fetch(16'h0002); push_wr(3'd2, 16'h0000);
    push_fetch(16'h0003); push_wr(3'd0, 16'h00FF);
    push_fetch(16'h00FF); push_rd(16'h0040); push_wr(3'd2, 16'h1234);
    push_fetch(16'h0100); push_wt(16'h00FF, 16'h1234);
    push_fetch(16'h0101); push_wr(3'd5, 16'h0100);
    push_fetch(16'h0102); push_wr(3'd5, 16'h0000);
    push_fetch(16'h0103); push_wr(3'd5, 16'h1234);
    push_fetch(16'h0104); push_wr(3'd7, 16'h00FF);
    push_fetch(16'h0105); push_wr(3'd5, 16'h0000);
    push_fetch(16'h0106); push_wr(3'd0, 16'h0200);
    push_fetch(16'h0200); push_rd(16'h00FF); push_wr(3'd3, 16'h1234);
    push_fetch(16'h0201);

    repeat (3) @(negedge clk);
    set_rst(1'b0);
    wait_halted(400, "phase1_halted");
    wait_drain(5, "phase1_drained");
    check("store_landed", mem_arr[16'h00FF], 16'h1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_no_req", {halted, mem_req}, 2'b10);
    end

    // phase 2: LD with 0xBEEF, then reset during a pending LD
    mem_arr[16'h0000] = 16'h8640;
    mem_arr[16'h0001] = 16'h8640;
    mem_arr[16'h00FF] = 16'hBEEF;
    set_rst(1'b1);
    push_fetch(16'h0000); push_rd(16'h00FF); push_wr(3'd3, 16'hBEEF);
    push_fetch(16'h0001);
    repeat (2) @(negedge clk);
    set_rst(1'b0);
    wait_drain(100, "phase2_first_ld");
    hold_ld = 1'b1;
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 16'h00FF); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("ld_pending_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h00FF});
    set_rst(1'b1);
    @(negedge clk);
    check("abort_req_low", {mem_req, in_en, pc_inc}, 3'b000);
    @(negedge clk);
    mem_arr[16'h0001] = 16'hF000;
    hold_ld = 1'b0;
    push_fetch(16'h0000); push_rd(16'h00FF); push_wr(3'd3, 16'hBEEF);
    push_fetch(16'h0001);
    set_rst(1'b0);
    wait_halted(100, "phase2_halted");
    wait_drain(5, "phase2_drained");
    check("r0_after_restart", gpr[0], 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer for the tiny16 core. It drives the control side of the register file: source and destination selects, write enable, output enable, PC increment and write-back data. It also consumes the file's registered src/dst read ports. It owns the instruction register, the zero flag, an internal ALU, and the req/ack memory handshake used for instruction fetch, LD and ST.

## Interface
- `RESET_PC`, 16'h0000 — documentation only; the register file resets R0 (the PC) and no reset value is held here.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `reg_src` in 16 — register file `src` port; registered copy of gpr[src_sel].
- `reg_dst` in 16 — register file `dst` port; registered copy of gpr[dst_sel].
- `src_sel` out 3 — register file source select.
- `dst_sel` out 3 — register file destination select.
- `in_en` out 1 — register write enable; writes `wb_data` into gpr[dst_sel].
- `out_en` out 1 — register file output enable.
- `pc_inc` out 1 — R0 increment strobe.
- `wb_data` out 16 — write-back data, wired to the register file `in`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16 — memory request.
- `mem_ack` in 1, `mem_rdata` in 16 — memory response.
- `halted` out 1 — high in the HALT state.

## Operation
- Instruction format: [15:12] opcode, [11:9] dst, [8:6] src, [5:0] imm6.
- Opcodes:
  - 0 NOP.
  - 1 MOV: dst←src.
  - 2 LDI: dst←sign-extended imm6.
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: dst←dst op src.
  - 8 LD: dst←mem[src].
  - 9 ST: mem[dst]←src.
  - A JMP: R0←src.
  - B JZ: R0←src if Z=1.
  - C–E: reserved, executed as NOP.
  - F HLT.
- States:
  - FETCH: src_sel=0 → FETCH_REQ.
  - FETCH_REQ: mem_req=1, mem_addr=reg_src (the PC). On mem_ack: ir←mem_rdata, pc_inc=1 → DECODE. Otherwise stay.
  - DECODE: src_sel=ir.src, dst_sel=ir.dst → EXEC.
  - EXEC: reg_src and reg_dst are now valid.
    - ALU/MOV/LDI: in_en=1 → FETCH.
    - JMP, or JZ with Z=1: dst_sel=0, in_en=1, wb_data=reg_src → FETCH.
    - JZ with Z=0, NOP, reserved: → FETCH.
    - LD/ST: → MEM.
    - HLT: → HALT.
  - MEM: mem_req=1.
    - LD: mem_addr=reg_src. On ack: in_en=1, wb_data=mem_rdata → FETCH.
    - ST: mem_we=1, mem_addr=reg_dst, mem_wdata=reg_src, out_en=1. On ack → FETCH.
  - HALT: absorbing; only `rst` leaves it.
- Arithmetic: ADD/SUB are modulo 2^16 with no carry. Z←(result==0) on ADD..XOR only. MOV, LDI, LD, JMP and JZ leave Z unchanged.
- src_sel and dst_sel hold their decoded values from DECODE through the end of EXEC/MEM.
- A destination of R0 on a data op is a legal jump. pc_inc is never asserted in the same cycle as in_en.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until a cycle in which mem_ack=1.
  - mem_req deasserts the cycle after the ack.
  - mem_ack is ignored when mem_req=0.

## Timing
- Reset values while rst=1: state FETCH, ir=0, Z=0. All outputs 0: src_sel, dst_sel, in_en, out_en, pc_inc, mem_req, mem_we, mem_addr, mem_wdata, wb_data, halted.
- Zero-wait memory: 4 cycles for ALU/jump/NOP, 5 cycles for LD/ST. Each cycle of ack delay adds one cycle.
- R0 read in EXEC returns PC+1: pc_inc lands before DECODE's select is sampled.
- A JMP write lands at the end of EXEC, so the next FETCH_REQ presents the new PC.
- Reset mid-transfer: the transfer is abandoned and mem_req is low in the cycle after rst is sampled. No in_en or pc_inc is issued.

## Structure
- Shared package `tiny16_pkg`: opcode enum, state enum, instruction field position constants.
- Sub-module `alu16`: combinational; inputs a=reg_dst, b=reg_src, op; outputs result and zero.

## Test plan
- Reset, then fetch of 0x243F (LDI R2,#-1) → first mem_addr=0x0000; exactly one pc_inc; in EXEC: in_en=1, dst_sel=2, wb_data=0xFFFF; Z stays 0.
- SUB R2,R2 (0x4480) with R2=0xFFFF → wb_data=0x0000, Z=1. Then JZ R1 (0xB040) with R1=0x00FF → dst_sel=0, in_en=1, wb_data=0x00FF; next mem_addr=0x00FF.
- Fetch with mem_ack delayed 3 cycles → mem_req high for 4 cycles, mem_addr stable throughout, pc_inc asserted exactly once.
- ST (0x9280) with R1=0x00FF, R2=0x1234 → mem_req=1, mem_we=1, mem_addr=0x00FF, mem_wdata=0x1234, out_en=1; no in_en.
- LD R3,[R1] (0x8640) with mem_rdata=0xBEEF → in_en=1, dst_sel=3, wb_data=0xBEEF on the ack cycle. rst asserted during the LD wait → no in_en, mem_req low next cycle, next fetch at 0x0000.
- HLT (0xF000) → halted=1; no mem_req for 20 cycles; rst returns to FETCH.
